// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a length-prefixed little-endian byte stream into
// word writes at byte addresses 0, 4, 8, ... Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StChk,
`endif
    StDone
  } state_e;

  localparam logic [8:0] DepthW = 9'(DEPTH);

  state_e      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [8:0]  word_cnt_q, word_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif
  logic        xfer;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == StLen) || (state_q == StData) || (state_q == StChk);
`else
  assign byte_ready = (state_q == StLen) || (state_q == StData);
`endif
  assign xfer = byte_valid & byte_ready;

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wr_data_d  = wr_data_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    unique case (state_q)
      StIdle: if (start) state_d = StLen;
      StLen: begin
        if (xfer) begin
          n_d = byte_data;
          if (byte_data == 8'd0 || {1'b0, byte_data} > DepthW) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            word_cnt_d = '0;
            byte_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_d      = '0;
`endif
            state_d    = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          wr_data_d[8*byte_cnt_q +: 8] = byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ byte_data;
`endif
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        word_cnt_d = word_cnt_q + 9'd1;
        if (word_cnt_d == {1'b0, n_q}) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = StChk;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StChk: begin
        if (xfer) begin
          err_d   = (byte_data != xor_q);
          state_d = StDone;
        end
      end
`endif
      StDone: begin
        if (start) begin
          err_d   = 1'b0;
          state_d = StLen;
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered outputs are decoded from the next state so they line up with it.
    wr_en_d    = (state_d == StWrite);
    busy_d     = (state_d != StIdle) && (state_d != StDone);
    done_d     = (state_d == StDone);
    cpu_hold_d = !(done_d && !err_d);
    wr_addr_d  = {21'd0, word_cnt_d, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random loads against a word-list model
// of the stream format; a bench-side memory collects every write strobe.
module tb_imem_loader;
  localparam int unsigned DEPTH = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CsOn = 1'b1;
`else
  localparam bit CsOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, wr_en, busy, done, err, cpu_hold;
  logic [31:0] wr_addr, wr_data;

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bench-side instruction memory and write log.
  int          wr_cnt = 0;
  logic [31:0] log_addr [1024];
  logic [31:0] log_data [1024];
  int unsigned log_cyc  [1024];
  logic [31:0] tb_mem   [256];
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      log_addr[wr_cnt % 1024] = wr_addr;
      log_data[wr_cnt % 1024] = wr_data;
      log_cyc[wr_cnt % 1024]  = cyc;
      tb_mem[wr_addr[9:2]]    = wr_data;
      wr_cnt++;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_words [256];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bit ok = 1'b0;
    byte_data  = b;
    byte_valid = 1'b1;
    start      = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (byte_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    if (!ok) chk("push_timeout", 32'(ok), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_load(input string tag, input int n, input int gap_max, input bit bad_sum,
                          input bit noise);
    int         base;
    bit         valid;
    bit         exp_err;
    int         exp_writes;
    logic [7:0] sum;
    logic [7:0] b;
    base  = wr_cnt;
    valid = (n >= 1) && (n <= int'(DEPTH));
    sum   = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, "_busy_len"}, 32'(busy), 32'd1);
    chk({tag, "_ready_len"}, 32'(byte_ready), 32'd1);
    push(8'(n));
    if (valid) begin
      for (int i = 0; i < n; i++) begin
        for (int j = 0; j < 4; j++) begin
          b   = exp_words[i][8*j +: 8];
          sum = sum ^ b;
          repeat ($urandom_range(0, gap_max)) begin
            if (noise) start = 1'($urandom);
            @(posedge clk);
            #1;
          end
          push(b);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      push(bad_sum ? (sum ^ 8'h01) : sum);
`endif
    end
    wait_done();
    exp_err    = !valid || (CsOn && bad_sum);
    exp_writes = valid ? n : 0;
    chk({tag, "_wr_count"}, 32'(wr_cnt - base), 32'(exp_writes));
    for (int k = 0; k < exp_writes; k++) begin
      chk({tag, "_addr"}, log_addr[(base + k) % 1024], 32'(4 * k));
      chk({tag, "_data"}, log_data[(base + k) % 1024], exp_words[k]);
    end
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
  endtask

  initial begin
    int base;
    // Reset held with start asserted.
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(byte_ready), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_addr", wr_addr, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_hold", 32'(cpu_hold), 32'd1);
    chk("rst_no_writes", 32'(wr_cnt), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(byte_ready), 32'd0);

    // Directed two-word load with valid held high.
    exp_words[0] = 32'hE3A00014;
    exp_words[1] = 32'hE3A01A01;
    base = wr_cnt;
    run_load("n2", 2, 0, 1'b0, 1'b0);
    chk("n2_spacing", log_cyc[(base + 1) % 1024] - log_cyc[base % 1024], 32'd5);

    // Illegal word counts.
    run_load("n0", 0, 0, 1'b0, 1'b0);
    run_load("n_over", int'(DEPTH) + 1, 0, 1'b0, 1'b0);

    // Full-depth random load with random gaps.
    for (int i = 0; i < int'(DEPTH); i++) exp_words[i] = $urandom;
    base = wr_cnt;
    run_load("full", int'(DEPTH), 3, 1'b0, 1'b0);
    chk("full_last_addr", log_addr[(base + int'(DEPTH) - 1) % 1024], 32'(4 * (DEPTH - 1)));
    for (int k = 0; k < int'(DEPTH); k++) chk("full_mem", tb_mem[k], exp_words[k]);

    // Reset after the first word of a 3-word load.
    exp_words[0] = 32'hA5C30F96;
    base  = wr_cnt;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(8'd3);
    for (int j = 0; j < 4; j++) push(exp_words[0][8*j +: 8]);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_writes", 32'(wr_cnt - base), 32'd1);
    chk("mid_rst_mem0", tb_mem[0], 32'hA5C30F96);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_hold", 32'(cpu_hold), 32'd1);
    chk("mid_rst_ready", 32'(byte_ready), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    for (int i = 0; i < 3; i++) exp_words[i] = $urandom;
    run_load("fresh", 3, 2, 1'b0, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_words[0] = 32'h11223344;
    run_load("cs_good", 1, 0, 1'b0, 1'b0);
    run_load("cs_bad", 1, 0, 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Sequential writer that fills the processor's word-addressed instruction memory from a byte stream before execution begins. It accepts a valid/ready byte stream, assembles little-endian 32-bit instruction words, and issues one memory write per word at word-aligned byte addresses 0, 4, 8, and so on. Those addresses match the fetch stage's `addr[31:2]` indexing. While loading, and after any failed load, it holds the processor core stalled.

## Interface
- `DEPTH`, 32, instruction memory capacity in words (power of two, ≤ 256)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE
- `byte_valid`  in  1  `byte_data` is valid this cycle
- `byte_data`  in  8  stream byte
- `byte_ready`  out  1  loader can accept a byte this cycle
- `wr_en`  out  1  instruction memory write strobe, one cycle per word
- `wr_addr`  out  32  byte address of the word being written; bits [1:0] always 0
- `wr_data`  out  32  assembled instruction word
- `busy`  out  1  load in progress
- `done`  out  1  load finished (success or error); held until `start` or `rst`
- `err`  out  1  load failed; valid while `done` = 1
- `cpu_hold`  out  1  stall or reset request to the core

## Operation
- Stream format:
  - Byte 0 is N, the word count.
  - The next 4·N bytes are the words, least-significant byte first.
  - With checksum enabled, one more byte follows (see Configuration).
- A byte transfers on any cycle where `byte_valid` and `byte_ready` are both 1.
- FSM states:
  - **IDLE**: `byte_ready` = 0. On `start`, go to LEN.
  - **LEN**: `byte_ready` = 1. On transfer, latch N. If N = 0 or N > DEPTH, set `err` and go to DONE with no writes. Otherwise clear the word and byte counters, set the address to 0, and go to DATA.
  - **DATA**: `byte_ready` = 1. Each transfer shifts the byte into lane `byte_cnt` of the assembly register. The 4th transfer goes to WRITE.
  - **WRITE**: `byte_ready` = 0. Assert `wr_en` with the current `wr_addr`/`wr_data` for exactly one cycle. Then add 4 to `wr_addr` and increment `word_cnt`. If `word_cnt` reaches N, go to CHK (macro defined) or DONE. Otherwise return to DATA.
  - **CHK**: see Configuration.
  - **DONE**: `done` = 1 and `byte_ready` = 0. On `start`, clear `done`/`err` and go to LEN.
- `start` in LEN, DATA, WRITE or CHK is ignored.
- `busy` = 1 in LEN, DATA, WRITE and CHK.
- `cpu_hold` = 1 in every state except DONE with `err` = 0.
- Address arithmetic: `wr_addr` = {word_cnt, 2'b00}, zero-extended to 32 bits. The last word written is at byte address 4·(N−1). No wrap-around is possible because N ≤ DEPTH is enforced.
- Reset mid-load:
  - Return to IDLE with all outputs at their reset values.
  - Words already written stay in memory; the loader never clears memory.
- Reset values:
  - `byte_ready` = 0, `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0
  - `busy` = 0, `done` = 0, `err` = 0, `cpu_hold` = 1

## Timing
- All outputs are registered, except `byte_ready`, which is decoded combinationally from state.
- Latency: the 4th byte of a word is accepted at edge k; `wr_en` is high during cycle k+1.
- Peak throughput is 4 bytes per 5 cycles.
- The stream source may hold `byte_valid` high continuously. The loader stalls it only in WRITE, CHK-decision and idle states.
- `done` rises one cycle after the final WRITE cycle (no checksum) or after the checksum byte is accepted.
- `cpu_hold` falls in the same cycle `done` rises, only when `err` = 0.

## Configuration
- Macro: `IMEM_LOADER_CHECKSUM_EN`.
- **Defined**:
  - The loader maintains a running XOR of all data bytes; the N byte is excluded.
  - After the last WRITE the FSM enters CHK with `byte_ready` = 1.
  - On transfer of the checksum byte, set `err` = 1 if it differs from the running XOR, then go to DONE.
  - Words already written are not rolled back; `cpu_hold` stays 1 on error.
- **Undefined**:
  - The CHK state, XOR register and checksum byte do not exist.
  - WRITE of the last word goes directly to DONE.

## Test plan
- Reset with `start` = 1: outputs hold reset values, `cpu_hold` = 1, no `wr_en` pulse.
- `start`, then stream N = 2 and bytes 14 00 A0 E3 01 1A A0 E3 with `byte_valid` held high:
  - Exactly two writes: addr 0x0 with data 0xE3A00014, then addr 0x4 with data 0xE3A01A01, each 5 cycles apart.
  - `done` = 1, `err` = 0, `cpu_hold` = 0.
- N = 0, then separately N = DEPTH+1: no `wr_en`, `done` = 1, `err` = 1, `cpu_hold` = 1.
- N = DEPTH with random data and random `byte_valid` gaps: DEPTH writes, last `wr_addr` = 4·(DEPTH−1), memory readback matches.
- `rst` asserted after 5 bytes of an N = 3 load:
  - The word at addr 0 remains in memory; FSM returns to IDLE.
  - A fresh load succeeds. `start` pulses during that load are ignored.
- With `IMEM_LOADER_CHECKSUM_EN` and N = 1, data 0x11223344:
  - Checksum byte 0x44 (0x11^0x22^0x33^0x44) gives `err` = 0.
  - Checksum byte 0x45 gives `err` = 1, `cpu_hold` = 1, and the word is still written.
